// File: rtl/jts16_fd1094_keysched.sv
// ----------------------------------------------------------------------------
// jts16_fd1094_keysched
//
// Key-table read scheduler for the FD1094 opcode decryptor. Every 68000
// opcode fetch inside the encrypted ROM window needs the per-address key
// byte. That byte lives in an 8 KB table in SDRAM. This block requests it,
// holds DTACK off while the read is outstanding, and then presents the key
// together with the FD1094 state byte that was current when the fetch began.
//
// Build option:
//   JTS16_FD1094_KCACHE_EN - adds a direct-mapped key cache with 2^CACHE_AW
//                            entries. A hit skips the SDRAM read. When the
//                            macro is undefined there is no cache storage.
//
// Ports:
//   rst       in   asynchronous, active-high reset
//   clk       in   system clock
//   asn       in   68000 address strobe, active low
//   op_n      in   low = program/opcode fetch (FC-derived)
//   addr      in   CPU word address [23:1]
//   st        in   current FD1094 state byte
//   key_addr  out  key-table byte address (addr[13:1]) for the current fetch
//   key_cs    out  SDRAM key read request, held until key_ok
//   key_ok    in   SDRAM data valid, one-cycle pulse
//   key_data  in   SDRAM key byte
//   key       out  key byte for the current fetch
//   st_out    out  state byte captured at the start of the fetch
//   key_valid out  key/st_out valid for the current bus cycle
//   hold_n    out  low = extend DTACK (CPU wait)
// ----------------------------------------------------------------------------
module jts16_fd1094_keysched #(
    parameter logic [23:1] ROM_END  = 23'h03_FFFF,
    parameter int unsigned CACHE_AW = 4
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        asn,
    input  logic        op_n,
    input  logic [23:1] addr,
    input  logic [7:0]  st,
    output logic [12:0] key_addr,
    output logic        key_cs,
    input  logic        key_ok,
    input  logic [7:0]  key_data,
    output logic [7:0]  key,
    output logic [7:0]  st_out,
    output logic        key_valid,
    output logic        hold_n
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StReq,
        StDone,
        StDrain
    } state_t;

    state_t      state_q, state_d;
    logic        asn_q, asn_qq;
    logic        asn_fall;
    logic        qualify;
    logic        hit;
    logic        hit_deliver;
    logic        miss_deliver;
    logic        fill;
    logic [7:0]  st_hold;
    logic [7:0]  hit_data;

    // ------------------------------------------------------------------
    // Address-strobe edge detect. Two flops: the falling edge is seen one
    // cycle after asn is first sampled low, which gives the FSM a full
    // cycle to decode addr/op_n before leaving IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asn_q  <= 1'b1;
            asn_qq <= 1'b1;
        end else begin
            asn_q  <= asn;
            asn_qq <= asn_q;
        end
    end

    assign asn_fall = asn_qq & ~asn_q;
    assign qualify  = asn_fall & ~op_n & (addr <= ROM_END);

    // ------------------------------------------------------------------
    // Optional key cache
    // ------------------------------------------------------------------
`ifdef JTS16_FD1094_KCACHE_EN
    localparam int unsigned Entries = 1 << CACHE_AW;
    localparam int unsigned TagW    = 13 - CACHE_AW;

    logic [Entries-1:0] cache_valid;
    logic [TagW-1:0]    cache_tag  [Entries];
    logic [7:0]         cache_data [Entries];
    logic [CACHE_AW-1:0] idx;
    logic [TagW-1:0]     tag;

    // key_addr is addr[13:1], so its low bits are addr[CACHE_AW:1].
    assign idx      = key_addr[CACHE_AW-1:0];
    assign tag      = key_addr[12:CACHE_AW];
    assign hit      = cache_valid[idx] && (cache_tag[idx] == tag);
    assign hit_data = cache_data[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= '0;
        end else if (fill) begin
            cache_valid[idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill) begin
            cache_tag[idx]  <= tag;
            cache_data[idx] <= key_data;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = 8'h00;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (qualify) state_d = StLookup;
            end
            StLookup: begin
                // A hit on an already-abandoned cycle has nobody to serve.
                if (hit) state_d = asn ? StIdle : StDone;
                else     state_d = StReq;
            end
            StReq: begin
                // asn high wins over a coincident key_ok: the CPU has moved
                // on, so the byte only goes to the cache (if any).
                if (asn)         state_d = key_ok ? StIdle : StDrain;
                else if (key_ok) state_d = StDone;
            end
            StDone: begin
                if (asn) state_d = StIdle;
            end
            StDrain: begin
                // The SDRAM slot cannot be cancelled; wait out the read.
                if (key_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        key_cs       = 1'b0;
        key_valid    = 1'b0;
        hold_n       = 1'b1;
        hit_deliver  = 1'b0;
        miss_deliver = 1'b0;
        fill         = 1'b0;
        unique case (state_q)
            StIdle: ;
            StLookup: begin
                hold_n      = asn;
                hit_deliver = hit & ~asn;
            end
            StReq: begin
                key_cs       = 1'b1;
                hold_n       = asn;
                miss_deliver = key_ok & ~asn;
                fill         = key_ok;
            end
            StDone: begin
                key_valid = 1'b1;
            end
            StDrain: begin
                key_cs = 1'b1;
                fill   = key_ok;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_addr <= 13'h0000;
            st_hold  <= 8'h00;
        end else if (state_q == StIdle && qualify) begin
            key_addr <= addr[13:1];
            // st is frozen here; later state changes belong to the next fetch.
            st_hold  <= st;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key    <= 8'h00;
            st_out <= 8'h00;
        end else if (miss_deliver) begin
            key    <= key_data;
            st_out <= st_hold;
        end else if (hit_deliver) begin
            key    <= hit_data;
            st_out <= st_hold;
        end
    end

endmodule

// File: tb/tb_jts16_fd1094_keysched.sv
module tb_jts16_fd1094_keysched;

    logic        rst;
    logic        clk;
    logic        asn;
    logic        op_n;
    logic [23:1] addr;
    logic [7:0]  st;
    logic [12:0] key_addr;
    logic        key_cs;
    logic        key_ok;
    logic [7:0]  key_data;
    logic [7:0]  key;
    logic [7:0]  st_out;
    logic        key_valid;
    logic        hold_n;

    int vectors = 0;
    int errors  = 0;

    jts16_fd1094_keysched dut (
        .rst       (rst),
        .clk       (clk),
        .asn       (asn),
        .op_n      (op_n),
        .addr      (addr),
        .st        (st),
        .key_addr  (key_addr),
        .key_cs    (key_cs),
        .key_ok    (key_ok),
        .key_data  (key_data),
        .key       (key),
        .st_out    (st_out),
        .key_valid (key_valid),
        .hold_n    (hold_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic end_cycle();
        asn  = 1'b1;
        op_n = 1'b1;
        tick();
        tick();
    endtask

    // Full miss transaction; key_ok is sampled n cycles after key_cs rises.
    task automatic fetch_miss(input logic [23:1] a, input logic [7:0] s,
                              input logic [12:0] ka, input logic [7:0] d, input int n);
        asn = 1'b0; op_n = 1'b0; addr = a; st = s;
        tick();                                   // asn sampled low: edge detect
        check("idle_hold", hold_n, 1);
        tick();                                   // LOOKUP
        check("lookup_addr", key_addr, ka);
        check("lookup_hold", hold_n, 0);
        check("lookup_cs", key_cs, 0);
        tick();                                   // REQ
        check("req_cs", key_cs, 1);
        repeat (n - 1) tick();
        check("wait_valid", key_valid, 0);
        check("wait_hold", hold_n, 0);
        key_ok = 1'b1; key_data = d;
        tick();                                   // edge detect + 2 + n
        key_ok = 1'b0; key_data = 8'h00;
        check("done_valid", key_valid, 1);
        check("done_key", key, d);
        check("done_st", st_out, s);
        check("done_hold", hold_n, 1);
        check("done_cs", key_cs, 0);
        tick();
        check("done_held", key_valid, 1);
        asn = 1'b1; op_n = 1'b1;
        tick();
        check("release_valid", key_valid, 0);
        tick();
    endtask

    task automatic bypass(input logic [23:1] a, input logic o);
        asn = 1'b0; op_n = o; addr = a; st = 8'h77;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bypass_cs", key_cs, 0);
            check("bypass_hold", hold_n, 1);
            check("bypass_valid", key_valid, 0);
        end
        end_cycle();
    endtask

    initial begin
        rst = 1'b1; asn = 1'b1; op_n = 1'b1; addr = '0; st = 8'h00;
        key_ok = 1'b0; key_data = 8'h00;
        #1;
        check("rst_cs", key_cs, 0);
        check("rst_valid", key_valid, 0);
        check("rst_hold", hold_n, 1);
        check("rst_key", key, 0);
        check("rst_st", st_out, 0);
        check("rst_kaddr", key_addr, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Basic miss
        fetch_miss(23'h000100, 8'h5A, 13'h0100, 8'hC3, 5);

`ifdef JTS16_FD1094_KCACHE_EN
        // Hit: no SDRAM request, key_valid two cycles after edge detect
        asn = 1'b0; op_n = 1'b0; addr = 23'h000100; st = 8'h66;
        tick();
        tick();
        check("hit_lookup_cs", key_cs, 0);
        check("hit_lookup_hold", hold_n, 0);
        tick();
        check("hit_valid", key_valid, 1);
        check("hit_key", key, 8'hC3);
        check("hit_st", st_out, 8'h66);
        check("hit_cs", key_cs, 0);
        end_cycle();
        // Same index, different tag (addr[13:5] differs) -> miss and refill
        fetch_miss(23'h001100, 8'h21, 13'h1100, 8'h9E, 2);
        // 0x100 was evicted -> miss again
        fetch_miss(23'h000100, 8'h22, 13'h0100, 8'hC3, 1);
`endif

        // Bypass: data read in window, opcode fetch just above window
        bypass(23'h000100, 1'b1);
        bypass(23'h040000, 1'b0);

        // Last encrypted word still qualifies
        fetch_miss(23'h03FFFF, 8'hA5, 13'h1FFF, 8'h3C, 1);

        // Abandon two cycles into REQ
        asn = 1'b0; op_n = 1'b0; addr = 23'h000200; st = 8'h11;
        tick(); tick(); tick();                   // REQ
        tick();
        asn = 1'b1; op_n = 1'b1;
        tick();                                   // DRAIN
        check("drain_cs", key_cs, 1);
        check("drain_hold", hold_n, 1);
        check("drain_valid", key_valid, 0);
        tick();
        check("drain_cs2", key_cs, 1);
        key_ok = 1'b1; key_data = 8'h77;
        tick();
        key_ok = 1'b0;
        check("drain_end_cs", key_cs, 0);
        check("drain_end_valid", key_valid, 0);
        check("drain_key_kept", key, 8'h3C);
        tick();
        check("drain_idle_valid", key_valid, 0);
        tick();

        // st changes while in REQ; st_out keeps the value from the edge
        asn = 1'b0; op_n = 1'b0; addr = 23'h000300; st = 8'h12;
        tick(); tick(); tick();                   // REQ
        st = 8'h34;
        tick();
        key_ok = 1'b1; key_data = 8'h5E;
        tick();
        key_ok = 1'b0;
        check("stchg_valid", key_valid, 1);
        check("stchg_st", st_out, 8'h12);
        check("stchg_key", key, 8'h5E);
        end_cycle();
        check("stchg_release", key_valid, 0);

        // Simultaneous key_ok and asn rise in REQ: abandoned
        asn = 1'b0; op_n = 1'b0; addr = 23'h000400; st = 8'h44;
        tick(); tick(); tick();                   // REQ
        asn = 1'b1; op_n = 1'b1; key_ok = 1'b1; key_data = 8'hEE;
        tick();
        key_ok = 1'b0;
        check("simul_valid", key_valid, 0);
        check("simul_cs", key_cs, 0);
        check("simul_key", key, 8'h5E);
        tick();
        check("simul_idle_cs", key_cs, 0);
        check("simul_idle_valid", key_valid, 0);
        tick();

        // Asynchronous reset in the middle of REQ
        asn = 1'b0; op_n = 1'b0; addr = 23'h000500; st = 8'hAB;
        tick(); tick(); tick();                   // REQ
        check("prerst_cs", key_cs, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_cs", key_cs, 0);
        check("arst_hold", hold_n, 1);
        check("arst_valid", key_valid, 0);
        check("arst_key", key, 0);
        asn = 1'b1; op_n = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        // Stray key_ok in IDLE must be ignored
        key_ok = 1'b1; key_data = 8'hEE;
        tick();
        key_ok = 1'b0;
        check("stray_valid", key_valid, 0);
        check("stray_key", key, 0);
        check("stray_cs", key_cs, 0);
        tick();

        // Normal operation after reset
        fetch_miss(23'h000100, 8'h5A, 13'h0100, 8'hC3, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
